// File: rtl/tmr8_dual_channel_core.sv
// -----------------------------------------------------------------------------
// tmr8_dual_channel_core
//
// Purpose:
//   One two-channel 8-bit timer unit.  It contains a free-running prescaler,
//   clock-source selection per channel, an up-counter per channel (TCNT), two
//   compare registers per channel (TCORA/TCORB) with match-event detection,
//   counter-clear control, compare-match output pins (TMO) and interrupt
//   flags.  Channel 1 can be cascaded onto channel 0 and vice versa.  Register
//   values come from the surrounding register file; this core holds only the
//   counters, flags, pins and synchronizers.
//
// Ports:
//   clk          system clock, every flop updates on posedge
//   rst_n        synchronous active-low reset
//   tmci[1:0]    external count clock per channel (asynchronous)
//   tmri[1:0]    external counter reset per channel (asynchronous)
//   tcr0/tcr1    [2:0] CKS, [4:3] CCLR, [5] OVIE, [6] CMIEA, [7] CMIEB
//   tcsr0/tcsr1  [1:0] OS_A, [3:2] OS_B, [4] ADTE (channel 0 only)
//   tcora0/1     compare constant A
//   tcorb0/1     compare constant B
//   tcnt_wr      one-cycle TCNT write strobe per channel
//   tcnt_wdata   TCNT write data shared by both channels
//   flag_clr     clear pulses {OVF1,CMFB1,CMFA1,OVF0,CMFB0,CMFA0}
//   tcnt0/tcnt1  counter values
//   cmia/cmib/ovi interrupt requests per channel (flag AND enable)
//   tmo          compare-match output pins
//   adc_request  single-cycle ADC start pulse
//
// Build option:
//   TMR_ADC_TRIG_EN  when defined, adc_request pulses on each channel 0
//                    match-A event while tcsr0[4] (ADTE) is set.  When not
//                    defined, adc_request is tied low and ADTE is ignored.
// -----------------------------------------------------------------------------
module tmr8_dual_channel_core #(
  parameter int BIT_WIDTH  = 8,
  parameter int PRESCALE_W = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           tmci,
  input  logic [1:0]           tmri,
  input  logic [BIT_WIDTH-1:0] tcr0,
  input  logic [BIT_WIDTH-1:0] tcr1,
  input  logic [BIT_WIDTH-1:0] tcsr0,
  input  logic [BIT_WIDTH-1:0] tcsr1,
  input  logic [BIT_WIDTH-1:0] tcora0,
  input  logic [BIT_WIDTH-1:0] tcora1,
  input  logic [BIT_WIDTH-1:0] tcorb0,
  input  logic [BIT_WIDTH-1:0] tcorb1,
  input  logic [1:0]           tcnt_wr,
  input  logic [BIT_WIDTH-1:0] tcnt_wdata,
  input  logic [5:0]           flag_clr,
  output logic [BIT_WIDTH-1:0] tcnt0,
  output logic [BIT_WIDTH-1:0] tcnt1,
  output logic [1:0]           cmia,
  output logic [1:0]           cmib,
  output logic [1:0]           ovi,
  output logic [1:0]           tmo,
  output logic                 adc_request
);

  // Count source selection.  Cascade is handled outside this function because
  // the cascade source differs per channel.
  function automatic logic count_sel(
    input logic [2:0] sel,
    input logic       t8,
    input logic       t64,
    input logic       t8192,
    input logic       casc,
    input logic       rise,
    input logic       fall
  );
    logic ev;
    case (sel)
      3'b001:  ev = t8;
      3'b010:  ev = t64;
      3'b011:  ev = t8192;
      3'b100:  ev = casc;
      3'b101:  ev = rise;
      3'b110:  ev = fall;
      3'b111:  ev = rise | fall;
      default: ev = 1'b0;
    endcase
    return ev;
  endfunction

  // Counter next-state with fixed priority:
  // write > external reset > compare clear > increment.
  function automatic logic [BIT_WIDTH-1:0] next_count(
    input logic                 wr,
    input logic [BIT_WIDTH-1:0] wdata,
    input logic                 ext_clr,
    input logic                 cnt,
    input logic                 cmp_hit,
    input logic [BIT_WIDTH-1:0] cur
  );
    logic [BIT_WIDTH-1:0] nxt;
    if (wr)
      nxt = wdata;
    else if (ext_clr)
      nxt = '0;
    else if (cnt && cmp_hit)
      nxt = '0;
    else if (cnt)
      nxt = cur + 1'b1;
    else
      nxt = cur;
    return nxt;
  endfunction

  // Output pin update.  When A and B events land in the same cycle the
  // strongest action wins: toggle, then drive 1, then drive 0, then hold.
  function automatic logic next_tmo(
    input logic       cur,
    input logic       hit_a,
    input logic [1:0] os_a,
    input logic       hit_b,
    input logic [1:0] os_b
  );
    logic tog;
    logic drv1;
    logic drv0;
    logic nxt;
    tog  = (hit_a && (os_a == 2'b11)) || (hit_b && (os_b == 2'b11));
    drv1 = (hit_a && (os_a == 2'b10)) || (hit_b && (os_b == 2'b10));
    drv0 = (hit_a && (os_a == 2'b01)) || (hit_b && (os_b == 2'b01));
    if (tog)
      nxt = ~cur;
    else if (drv1)
      nxt = 1'b1;
    else if (drv0)
      nxt = 1'b0;
    else
      nxt = cur;
    return nxt;
  endfunction

  logic [PRESCALE_W-1:0] prescale_q;
  logic                  tick8;
  logic                  tick64;
  logic                  tick8192;

  logic [1:0] tmci_s1, tmci_s2, tmci_s3;
  logic [1:0] tmri_s1, tmri_s2, tmri_s3;
  logic [1:0] tmci_rise, tmci_fall, tmri_rise;

  logic [BIT_WIDTH-1:0] tcnt0_q, tcnt1_q;

  logic [2:0] cks0, cks1;
  logic [1:0] cclr0, cclr1;

  logic [1:0] match_a, match_b;
  logic [1:0] match_a_d, match_b_d;
  logic [1:0] ev_a, ev_b;

  logic cmp_hit0, cmp_hit1;
  logic tmri_clr0, tmri_clr1;
  logic casc_ok;
  logic cnt_ev0, cnt_ev1;
  logic ovf_ev0, ovf_ev1;

  logic [1:0] cmfa_q, cmfb_q, ovf_q, tmo_q;

  logic unused_tcsr;

  // Prescaler taps: each tick is high for exactly one clock per period.
  assign tick8    = &prescale_q[2:0];
  assign tick64   = &prescale_q[5:0];
  assign tick8192 = &prescale_q;

  // Two-flop synchronizers plus one history flop for edge detection.  An edge
  // on a pin reaches the counter on the third clock after it arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmci_s1 <= '0;
      tmci_s2 <= '0;
      tmci_s3 <= '0;
      tmri_s1 <= '0;
      tmri_s2 <= '0;
      tmri_s3 <= '0;
    end else begin
      tmci_s1 <= tmci;
      tmci_s2 <= tmci_s1;
      tmci_s3 <= tmci_s2;
      tmri_s1 <= tmri;
      tmri_s2 <= tmri_s1;
      tmri_s3 <= tmri_s2;
    end
  end

  assign tmci_rise = tmci_s2 & ~tmci_s3;
  assign tmci_fall = ~tmci_s2 & tmci_s3;
  assign tmri_rise = tmri_s2 & ~tmri_s3;

  assign cks0  = tcr0[2:0];
  assign cks1  = tcr1[2:0];
  assign cclr0 = tcr0[4:3];
  assign cclr1 = tcr1[4:3];

  // Compare levels and their first-cycle events.
  assign match_a = {(tcnt1_q == tcora1), (tcnt0_q == tcora0)};
  assign match_b = {(tcnt1_q == tcorb1), (tcnt0_q == tcorb0)};
  assign ev_a    = match_a & ~match_a_d;
  assign ev_b    = match_b & ~match_b_d;

  assign cmp_hit0  = ((cclr0 == 2'b01) && match_a[0]) || ((cclr0 == 2'b10) && match_b[0]);
  assign cmp_hit1  = ((cclr1 == 2'b01) && match_a[1]) || ((cclr1 == 2'b10) && match_b[1]);
  assign tmri_clr0 = (cclr0 == 2'b11) && tmri_rise[0];
  assign tmri_clr1 = (cclr1 == 2'b11) && tmri_rise[1];

  // Both channels in cascade mode would chase each other; neither counts.
  assign casc_ok = !((cks0 == 3'b100) && (cks1 == 3'b100));

  // Channel 1 is resolved first: its cascade source is channel 0's match-A
  // event (a pure function of registered state), and channel 0's cascade
  // source is channel 1's overflow, so there is no combinational loop.
  assign cnt_ev1 = casc_ok && count_sel(cks1, tick8, tick64, tick8192,
                                        ev_a[0], tmci_rise[1], tmci_fall[1]);
  assign ovf_ev1 = cnt_ev1 && (tcnt1_q == '1) && !cmp_hit1 && !tmri_clr1 && !tcnt_wr[1];

  assign cnt_ev0 = casc_ok && count_sel(cks0, tick8, tick64, tick8192,
                                        ovf_ev1, tmci_rise[0], tmci_fall[0]);
  assign ovf_ev0 = cnt_ev0 && (tcnt0_q == '1) && !cmp_hit0 && !tmri_clr0 && !tcnt_wr[0];

  // Prescaler, counters, match history, flags and output pins.  A flag set
  // in the same cycle as its clear pulse stays set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescale_q <= '0;
      tcnt0_q    <= '0;
      tcnt1_q    <= '0;
      match_a_d  <= '0;
      match_b_d  <= '0;
      cmfa_q     <= '0;
      cmfb_q     <= '0;
      ovf_q      <= '0;
      tmo_q      <= '0;
    end else begin
      prescale_q <= prescale_q + 1'b1;

      tcnt0_q <= next_count(tcnt_wr[0], tcnt_wdata, tmri_clr0, cnt_ev0, cmp_hit0, tcnt0_q);
      tcnt1_q <= next_count(tcnt_wr[1], tcnt_wdata, tmri_clr1, cnt_ev1, cmp_hit1, tcnt1_q);

      match_a_d <= match_a;
      match_b_d <= match_b;

      cmfa_q[0] <= ev_a[0] | (cmfa_q[0] & ~flag_clr[0]);
      cmfb_q[0] <= ev_b[0] | (cmfb_q[0] & ~flag_clr[1]);
      ovf_q[0]  <= ovf_ev0 | (ovf_q[0]  & ~flag_clr[2]);
      cmfa_q[1] <= ev_a[1] | (cmfa_q[1] & ~flag_clr[3]);
      cmfb_q[1] <= ev_b[1] | (cmfb_q[1] & ~flag_clr[4]);
      ovf_q[1]  <= ovf_ev1 | (ovf_q[1]  & ~flag_clr[5]);

      tmo_q[0] <= next_tmo(tmo_q[0], ev_a[0], tcsr0[1:0], ev_b[0], tcsr0[3:2]);
      tmo_q[1] <= next_tmo(tmo_q[1], ev_a[1], tcsr1[1:0], ev_b[1], tcsr1[3:2]);
    end
  end

  assign tcnt0 = tcnt0_q;
  assign tcnt1 = tcnt1_q;
  assign cmia  = cmfa_q & {tcr1[6], tcr0[6]};
  assign cmib  = cmfb_q & {tcr1[7], tcr0[7]};
  assign ovi   = ovf_q  & {tcr1[5], tcr0[5]};
  assign tmo   = tmo_q;

`ifdef TMR_ADC_TRIG_EN
  logic adc_q;

  // ADC start is a registered copy of channel 0's match-A event, gated by ADTE.
  always_ff @(posedge clk) begin
    if (!rst_n)
      adc_q <= 1'b0;
    else
      adc_q <= ev_a[0] & tcsr0[4];
  end

  assign adc_request = adc_q;
`else
  assign adc_request = 1'b0;
`endif

  // Upper status bits carry no function in this core.
  assign unused_tcsr = ^{tcsr0[BIT_WIDTH-1:4], tcsr1[BIT_WIDTH-1:4]};

endmodule

// File: tb/tb_tmr8_dual_channel_core.sv
// -----------------------------------------------------------------------------
// tb_tmr8_dual_channel_core
//
// Directed bench for tmr8_dual_channel_core.  Each section starts from a
// reset so the prescaler phase is known: after release, a clk/8 channel
// increments on the 8th, 16th, 24th ... rising edge.  Inputs change and
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_tmr8_dual_channel_core;

  logic       clk;
  logic       rst_n;
  logic [1:0] tmci;
  logic [1:0] tmri;
  logic [7:0] tcr0, tcr1, tcsr0, tcsr1;
  logic [7:0] tcora0, tcora1, tcorb0, tcorb1;
  logic [1:0] tcnt_wr;
  logic [7:0] tcnt_wdata;
  logic [5:0] flag_clr;
  logic [7:0] tcnt0, tcnt1;
  logic [1:0] cmia, cmib, ovi, tmo;
  logic       adc_request;

  int passed_checks = 0;
  int failed_checks = 0;
  int total_checks  = 0;

`ifdef TMR_ADC_TRIG_EN
  localparam logic [7:0] ADC_EXP = 8'd1;
`else
  localparam logic [7:0] ADC_EXP = 8'd0;
`endif

  tmr8_dual_channel_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tmci        (tmci),
    .tmri        (tmri),
    .tcr0        (tcr0),
    .tcr1        (tcr1),
    .tcsr0       (tcsr0),
    .tcsr1       (tcsr1),
    .tcora0      (tcora0),
    .tcora1      (tcora1),
    .tcorb0      (tcorb0),
    .tcorb1      (tcorb1),
    .tcnt_wr     (tcnt_wr),
    .tcnt_wdata  (tcnt_wdata),
    .flag_clr    (flag_clr),
    .tcnt0       (tcnt0),
    .tcnt1       (tcnt1),
    .cmia        (cmia),
    .cmib        (cmib),
    .ovi         (ovi),
    .tmo         (tmo),
    .adc_request (adc_request)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else begin
      failed_checks++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One reset edge; returns on the falling edge where rst_n is released.
  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [1:0] wr, input logic [7:0] data);
    tcnt_wr    = wr;
    tcnt_wdata = data;
  endtask

  initial begin
    rst_n      = 1'b0;
    tmci       = '0;
    tmri       = '0;
    tcr0       = 8'h00;
    tcr1       = 8'h00;
    tcsr0      = 8'h00;
    tcsr1      = 8'h00;
    tcora0     = 8'hFF;
    tcora1     = 8'hFF;
    tcorb0     = 8'hFF;
    tcorb1     = 8'hFF;
    tcnt_wr    = '0;
    tcnt_wdata = '0;
    flag_clr   = '0;

    // Power-on reset
    @(negedge clk);
    check_output("rst_tcnt0", tcnt0, 8'h00);
    check_output("rst_tcnt1", tcnt1, 8'h00);
    check_output("rst_irq",   {2'b00, cmia, cmib, ovi}, 8'h00);
    check_output("rst_tmo",   {6'd0, tmo}, 8'h00);
    check_output("rst_adc",   {7'd0, adc_request}, 8'h00);

    // clk/8, compare-A 5 with clear, toggle output, CMIEA on
    $display("[TB] ch0 compare clear and toggle");
    tcr0   = 8'h49;
    tcsr0  = 8'h03;
    tcora0 = 8'h05;
    apply_reset();
    run_cycles(40);
    check_output("cmp_tcnt_at5",   tcnt0, 8'h05);
    check_output("cmp_tmo_before", {6'd0, tmo}, 8'h00);
    check_output("cmp_cmia_before",{6'd0, cmia}, 8'h00);
    run_cycles(1);
    check_output("cmp_cmia_set",   {6'd0, cmia}, 8'h01);
    check_output("cmp_tmo_toggle1",{6'd0, tmo}, 8'h01);
    run_cycles(7);
    check_output("cmp_clear_to0",  tcnt0, 8'h00);
    run_cycles(2);
    flag_clr = 6'h01;
    run_cycles(1);
    flag_clr = 6'h00;
    check_output("cmp_cmia_cleared", {6'd0, cmia}, 8'h00);
    run_cycles(37);
    check_output("cmp_tcnt_second5", tcnt0, 8'h05);
    check_output("cmp_cmia_not_yet", {6'd0, cmia}, 8'h00);
    run_cycles(1);
    check_output("cmp_cmia_again",   {6'd0, cmia}, 8'h01);
    check_output("cmp_tmo_toggle2",  {6'd0, tmo}, 8'h00);

    // Reset while running, then counter holds 0 until the first tick
    $display("[TB] reset during count");
    apply_reset();
    check_output("midrst_tcnt0", tcnt0, 8'h00);
    check_output("midrst_cmia",  {6'd0, cmia}, 8'h00);
    check_output("midrst_tmo",   {6'd0, tmo}, 8'h00);
    run_cycles(7);
    check_output("midrst_hold0", tcnt0, 8'h00);
    run_cycles(1);
    check_output("midrst_first", tcnt0, 8'h01);

    // Overflow flag and set-beats-clear
    $display("[TB] ch0 overflow");
    tcr0  = 8'h21;
    tcsr0 = 8'h00;
    apply_reset();
    apply_stimulus(2'b01, 8'hFE);
    run_cycles(1);
    apply_stimulus(2'b00, 8'h00);
    check_output("ovf_write", tcnt0, 8'hFE);
    run_cycles(7);
    check_output("ovf_ff",      tcnt0, 8'hFF);
    check_output("ovf_ovi_pre", {6'd0, ovi}, 8'h00);
    run_cycles(8);
    check_output("ovf_wrap",    tcnt0, 8'h00);
    check_output("ovf_ovi_set", {6'd0, ovi}, 8'h01);
    flag_clr = 6'h04;
    run_cycles(1);
    flag_clr = 6'h00;
    check_output("ovf_ovi_clr", {6'd0, ovi}, 8'h00);
    apply_stimulus(2'b01, 8'hFF);
    run_cycles(1);
    apply_stimulus(2'b00, 8'h00);
    run_cycles(5);
    flag_clr = 6'h04;
    run_cycles(1);
    flag_clr = 6'h00;
    check_output("ovf_set_wins", {6'd0, ovi}, 8'h01);
    check_output("ovf_wrap2",    tcnt0, 8'h00);

    // Cascade: ch1 counts on ch0 match-A events
    $display("[TB] cascade");
    tcr0   = 8'h09;
    tcora0 = 8'h03;
    tcr1   = 8'h04;
    apply_reset();
    run_cycles(24);
    check_output("casc_tcnt0_3",  tcnt0, 8'h03);
    check_output("casc_tcnt1_0",  tcnt1, 8'h00);
    run_cycles(1);
    check_output("casc_tcnt1_1",  tcnt1, 8'h01);
    run_cycles(31);
    check_output("casc_tcnt1_1b", tcnt1, 8'h01);
    run_cycles(1);
    check_output("casc_tcnt1_2",  tcnt1, 8'h02);
    tcr0 = 8'h0C;
    run_cycles(1);
    apply_stimulus(2'b01, 8'h00);
    run_cycles(1);
    apply_stimulus(2'b00, 8'h00);
    run_cycles(1);
    apply_stimulus(2'b01, 8'h03);
    run_cycles(1);
    apply_stimulus(2'b00, 8'h00);
    run_cycles(3);
    check_output("casc_both_tcnt1", tcnt1, 8'h02);
    check_output("casc_both_tcnt0", tcnt0, 8'h03);

    // External clock both edges, external reset and write priority on ch1
    $display("[TB] ch1 external clock and reset");
    tcr0   = 8'h00;
    tcora0 = 8'hFF;
    tcr1   = 8'h1F;
    apply_reset();
    tmci[1] = 1'b1;
    run_cycles(2);
    check_output("ext_latency", tcnt1, 8'h00);
    run_cycles(1);
    check_output("ext_first",   tcnt1, 8'h01);
    tmci[1] = 1'b0;
    run_cycles(2);
    tmci[1] = 1'b1;
    run_cycles(2);
    tmci[1] = 1'b0;
    run_cycles(3);
    check_output("ext_four",    tcnt1, 8'h04);
    tmri[1] = 1'b1;
    run_cycles(2);
    check_output("tmri_latency", tcnt1, 8'h04);
    run_cycles(1);
    check_output("tmri_clear",   tcnt1, 8'h00);
    apply_stimulus(2'b10, 8'h77);
    run_cycles(1);
    apply_stimulus(2'b00, 8'h00);
    tmri[1] = 1'b0;
    check_output("wr_ch1", tcnt1, 8'h77);
    run_cycles(2);
    tmri[1] = 1'b1;
    run_cycles(2);
    apply_stimulus(2'b10, 8'h55);
    run_cycles(1);
    apply_stimulus(2'b00, 8'h00);
    check_output("wr_beats_tmri", tcnt1, 8'h55);
    tmri[1] = 1'b0;

    // ADC trigger on ch0 match-A
    $display("[TB] adc trigger");
    tcr1   = 8'h00;
    tcr0   = 8'h09;
    tcora0 = 8'h02;
    tcsr0  = 8'h10;
    apply_reset();
    run_cycles(16);
    check_output("adc_tcnt2",  tcnt0, 8'h02);
    check_output("adc_before", {7'd0, adc_request}, 8'h00);
    run_cycles(1);
    check_output("adc_pulse",  {7'd0, adc_request}, ADC_EXP);
    run_cycles(1);
    check_output("adc_after",  {7'd0, adc_request}, 8'h00);
    run_cycles(23);
    check_output("adc_pulse2", {7'd0, adc_request}, ADC_EXP);
    check_output("adc_tmo_hold", {6'd0, tmo}, 8'h00);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
